// File: rtl/oc8051_fetch_pkg.sv
// Shared definitions for the oc8051 program-memory fetch controller:
// state encoding, default timeout and per-byte address offsets.
package oc8051_fetch_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INT_RD = 3'd1;
  localparam logic [2:0] ST_EXT_B0 = 3'd2;
  localparam logic [2:0] ST_EXT_B1 = 3'd3;
  localparam logic [2:0] ST_EXT_B2 = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam int EXT_TIMEOUT_DEF = 16;

  localparam logic [15:0] OFS_B0 = 16'd0;
  localparam logic [15:0] OFS_B1 = 16'd1;
  localparam logic [15:0] OFS_B2 = 16'd2;

  // Successor of an external byte state once its byte has been acknowledged.
  function automatic logic [2:0] ext_next(input logic [2:0] st);
    case (st)
      ST_EXT_B0: return ST_EXT_B1;
      ST_EXT_B1: return ST_EXT_B2;
      default:   return ST_DONE;
    endcase
  endfunction

endpackage

// File: rtl/oc8051_fetch_tmo.sv
// External-bus timeout counter: counts strobe cycles without acknowledge,
// flags the cycle in which the count reaches LIMIT.
module oc8051_fetch_tmo
  import oc8051_fetch_pkg::*;
#(
  parameter int LIMIT = EXT_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] LIMIT_C = 8'(LIMIT);
  localparam logic [7:0] LAST_C  = 8'(LIMIT - 1);

  logic [7:0] cnt_q;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && cnt_q != LIMIT_C) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Asserted in the strobe cycle that would bring the count to LIMIT.
  assign tc = en && (cnt_q == LAST_C);

endmodule

// File: rtl/oc8051_fetch_ctrl.sv
// oc8051 instruction fetch controller: three code bytes per request, from the
// internal ROM in two cycles or byte-by-byte over the external code bus.
module oc8051_fetch_ctrl
  import oc8051_fetch_pkg::*;
#(
  parameter int INT_ROM_WID = 7,
  parameter int EXT_TIMEOUT = EXT_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [7:0]  op1,
  output logic [7:0]  op2,
  output logic [7:0]  op3,
  output logic [15:0] rom_addr,
  input  logic        ea_int,
  input  logic [7:0]  rom_data1,
  input  logic [7:0]  rom_data2,
  input  logic [7:0]  rom_data3,
  output logic        ext_stb,
  output logic [15:0] ext_addr,
  input  logic [7:0]  ext_dat,
  input  logic        ext_ack
);

  if (INT_ROM_WID < 1 || INT_ROM_WID > 16) begin : g_bad_rom_wid
    $error("INT_ROM_WID out of range");
  end
  if (EXT_TIMEOUT < 2 || EXT_TIMEOUT > 255) begin : g_bad_timeout
    $error("EXT_TIMEOUT out of range");
  end

  logic [2:0]  state_q, state_d;
  logic [15:0] addr_q;
  logic        stb_q, stb_d;
  logic [7:0]  b0_q, b1_q;
  logic [7:0]  op1_q, op2_q, op3_q;
  logic        err_q;
  logic [15:0] ofs;
  logic        in_ext;
  logic        byte_ack;
  logic        tmo_tc;

  // ext_stb is only ever high inside an EXT state, so a stray ack is ignored.
  assign byte_ack = stb_q && ext_ack;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    in_ext = 1'b0;
    ofs    = OFS_B0;
    case (state_q)
      ST_EXT_B0: begin in_ext = 1'b1; ofs = OFS_B0; end
      ST_EXT_B1: begin in_ext = 1'b1; ofs = OFS_B1; end
      ST_EXT_B2: begin in_ext = 1'b1; ofs = OFS_B2; end
      default:   ;
    endcase
  end

  // Each byte state spends one cycle with the strobe low before raising it.
  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    case (state_q)
      ST_IDLE:   if (cpu_req) state_d = ea_int ? ST_INT_RD : ST_EXT_B0;
      ST_INT_RD: state_d = ST_DONE;
      ST_EXT_B0, ST_EXT_B1, ST_EXT_B2: begin
        if (byte_ack) begin
          stb_d   = 1'b0;
          state_d = ext_next(state_q);
        end else if (tmo_tc) begin
          stb_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          stb_d   = 1'b1;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  oc8051_fetch_tmo #(
    .LIMIT (EXT_TIMEOUT)
  ) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (state_d != state_q),
    .en  (stb_q && !ext_ack),
    .tc  (tmo_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stb_q   <= 1'b0;
      addr_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      op3_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      if (state_q == ST_IDLE && cpu_req) addr_q <= cpu_addr;
      if (state_q == ST_INT_RD) begin
        op1_q <= rom_data1;
        op2_q <= rom_data2;
        op3_q <= rom_data3;
        err_q <= 1'b0;
      end
      // External results commit only on completion; missing bytes read as 00.
      if (in_ext && state_d == ST_DONE) begin
        err_q <= !byte_ack;
        case (state_q)
          ST_EXT_B0: begin op1_q <= 8'h00; op2_q <= 8'h00; op3_q <= 8'h00; end
          ST_EXT_B1: begin op1_q <= b0_q;  op2_q <= 8'h00; op3_q <= 8'h00; end
          default: begin
            op1_q <= b0_q;
            op2_q <= b1_q;
            op3_q <= byte_ack ? ext_dat : 8'h00;
          end
        endcase
      end
    end
  end

  // NOTE: staging bytes carry no reset; they are always written before being committed.
  always_ff @(posedge clk) begin
    if (byte_ack && state_q == ST_EXT_B0) b0_q <= ext_dat;
    if (byte_ack && state_q == ST_EXT_B1) b1_q <= ext_dat;
  end

  assign rom_addr = (state_q == ST_IDLE) ? cpu_addr : addr_q;
  assign ext_addr = addr_q + ofs;
  assign ext_stb  = stb_q;
  assign cpu_ack  = (state_q == ST_DONE);
  assign cpu_err  = err_q;
  assign op1      = op1_q;
  assign op2      = op2_q;
  assign op3      = op3_q;

endmodule
